// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//   state_e   : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   cnt_width : bit-counter width for a given operand width (never below 1)
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits are
    // enough. WIDTH=1 would give zero bits, so it is floored at one.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder_v1.sv
// One-bit full adder cell, purely combinational.
// Ports:
//   a, b, cin : operand bits and carry-in
//   s         : sum bit
//   cout      : carry-out
module full_adder_v1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial addition sequencer: {cout,sum} = a + b + cin, computed one bit
// per clock LSB-first through a single full_adder_v1 cell.
// Ports:
//   clk, rst_n : clock (rising edge), synchronous active-low reset
//   start      : request; accepted in IDLE or DONE, ignored while busy
//   a, b, cin  : operands, captured on the accepting edge
//   busy       : high while the addition is running (state RUN)
//   done       : one-cycle pulse when sum/cout have just been updated
//   sum, cout  : registered result, held until the next completion
// Handshake: a request is taken on any rising edge where start=1 and busy=0;
// the matching done pulse appears WIDTH edges later. Requests made while
// busy=1 are dropped, never queued.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_shift;

    full_adder_v1 u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the
    // result lines up with bit 0 of the operands. Going through a
    // WIDTH+1 concatenation keeps this legal for WIDTH=1.
    assign res_cat   = {fa_s, res_q};
    assign res_shift = res_cat[WIDTH:1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            // DONE accepts a new request exactly like IDLE, which gives
            // back-to-back operation without a bubble cycle.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                carry_d = fa_co;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = res_shift;
                    cout_d  = fa_co;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8): directed scenarios with literal
// expectations, plus a cycle-level reference model checked every cycle.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Abstract view: an accepted request yields a+b+cin exactly WIDTH edges
    // later; until then the unit is busy and ignores further requests.
    int             m_left  = 0;
    logic [WIDTH:0] m_pend  = '0;
    logic [WIDTH:0] m_res   = '0;
    logic           m_done  = 1'b0;
    bit             m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left  = 0;
            m_res   = '0;
            m_done  = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_res  = m_pend;
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_pend = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                m_left = WIDTH;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 33'(busy), 33'(m_left > 0));
            check("done", 33'(done), 33'(m_done));
            check("result", 33'({cout, sum}), 33'(m_res));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom_range(0, 255));
        b     = WIDTH'($urandom_range(0, 255));
        cin   = 1'($urandom_range(0, 1));
    endtask

    // Called right after issue(): counts busy cycles (the one seen by
    // issue's last negedge included) until done, bounded.
    task automatic wait_done(input string nm, output int busy_cyc, output bit got);
        busy_cyc = busy ? 1 : 0;
        got      = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
        end
        if (!got) check({nm, "_timeout"}, 33'(0), 33'(1));
    endtask

    // ---------------- directed scenarios ----------------
    typedef struct { logic [7:0] av; logic [7:0] bv; logic [8:0] res; } vec_t;
    vec_t t5_vec[4];

    initial begin
        int  bc;
        bit  got;
        int  ndone;
        int  last_cyc;
        int  cyc;
        int  idx;

        t5_vec[0] = '{8'h12, 8'h34, 9'h046};
        t5_vec[1] = '{8'hF0, 8'h10, 9'h100};
        t5_vec[2] = '{8'h80, 8'h81, 9'h101};
        t5_vec[3] = '{8'h7F, 8'h01, 9'h080};

        // T1 reset with start held high
        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'hC3;
        cin   = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_busy", 33'(busy), 33'(0));
        check("t1_done", 33'(done), 33'(0));
        check("t1_sum",  33'(sum),  33'(0));
        check("t1_cout", 33'(cout), 33'(0));
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // T2 basic add
        issue(8'h35, 8'h4A, 1'b0);
        wait_done("t2", bc, got);
        check("t2_busy_cycles", 33'(bc), 33'(8));
        check("t2_sum",  33'(sum),  33'(8'h7F));
        check("t2_cout", 33'(cout), 33'(0));
        @(negedge clk);
        check("t2_done_one_cycle", 33'(done), 33'(0));
        check("t2_sum_held", 33'(sum), 33'(8'h7F));

        // T3 full carry chain
        issue(8'hFF, 8'h00, 1'b1);
        wait_done("t3", bc, got);
        check("t3_sum",  33'(sum),  33'(8'h00));
        check("t3_cout", 33'(cout), 33'(1));

        // T4 start while busy is ignored
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        @(negedge clk);              // E0 has passed
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;   // sampled at E0+3
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        bc    = 4;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                ndone++;
                check("t4_sum",  33'(sum),  33'(8'h30));
                check("t4_cout", 33'(cout), 33'(0));
            end
        end
        check("t4_done_count", 33'(ndone), 33'(1));
        check("t4_busy_cycles", 33'(bc), 33'(8));

        // T5 back-to-back, start held high
        @(negedge clk);
        start = 1'b1; a = t5_vec[0].av; b = t5_vec[0].bv; cin = 1'b0;
        idx      = 0;
        last_cyc = 0;
        for (cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                check("t5_result", 33'({cout, sum}), 33'(t5_vec[idx].res));
                check("t5_gap", 33'(cyc - last_cyc), 33'(9));
                last_cyc = cyc;
                idx++;
                if (idx == 4) begin
                    start = 1'b0;
                    break;
                end
                a = t5_vec[idx].av;
                b = t5_vec[idx].bv;
            end
        end
        check("t5_done_count", 33'(idx), 33'(4));
        @(negedge clk);
        check("t5_idle_after", 33'(busy), 33'(0));

        // T6 reset mid-operation
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
        @(negedge clk);              // E0 has passed
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;                // sampled at E0+4
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_busy", 33'(busy), 33'(0));
        check("t6_sum",  33'(sum),  33'(0));
        check("t6_cout", 33'(cout), 33'(0));
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t6_no_done", 33'(ndone), 33'(0));
        issue(8'h12, 8'h34, 1'b1);
        wait_done("t6", bc, got);
        check("t6_sum_after",  33'(sum),  33'(8'h47));
        check("t6_cout_after", 33'(cout), 33'(0));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
